// File: rtl/sensor_cap_pkg.sv
// Shared types and constants for the TDC sample capture engine.
package sensor_cap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DUMP,
        ST_FIN
    } cap_state_t;

    localparam int          DEPTH_DEFAULT     = 2048;
    localparam int          ADDR_W            = $clog2(DEPTH_DEFAULT);
    localparam logic [7:0]  MARK_CODE_DEFAULT = 8'hFF;

endpackage

// File: rtl/sensor_trace_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module trace_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Read data holds while i_re is low so the readout pipeline can stall on it.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sensor_trace_capture.sv
// Circular pre/post-trigger capture of TDC samples with byte-stream readout.
module sensor_trace_capture
    import sensor_cap_pkg::*;
#(
    parameter int                  CHANNELS  = 2,
    parameter int                  SAMPLE_W  = 8,
    parameter int                  DEPTH     = DEPTH_DEFAULT,
    parameter int                  DECIM_W   = 8,
    parameter logic [SAMPLE_W-1:0] MARK_CODE = MARK_CODE_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         sample_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
    input  logic                         mark,
    input  logic                         arm,
    input  logic                         trig,
    input  logic                         abort,
    input  logic [$clog2(DEPTH)-1:0]     pretrig_len,
    input  logic [DECIM_W-1:0]           decim,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic                         triggered,
    output logic                         done
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DATA_W = CHANNELS * SAMPLE_W;
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);

    cap_state_t          r_state;
    cap_state_t          w_state_next;
    logic [AW-1:0]       r_pre_len;
    logic [DECIM_W-1:0]  r_decim;
    logic [DECIM_W-1:0]  r_dec_cnt;
    logic [AW-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_triggered;
    logic                r_done;

    logic [CH_W-1:0]     r_rd_ch;
    logic [AW-1:0]       r_rd_i;
    logic                r_issue_done;
    logic                r_s1_valid;
    logic [CH_W-1:0]     r_s1_ch;
    logic                r_s1_last;
    logic                r_tx_valid;
    logic [SAMPLE_W-1:0] r_tx_data;
    logic                r_tx_last;

    logic                w_capturing;
    logic                w_accept;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [CNT_W-1:0]    w_post_len;
    logic                w_pre_last;
    logic                w_post_last;
    logic                w_out_free;
    logic                w_take;
    logic                w_issue;
    logic                w_final_issue;
    logic                w_last_accept;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_ram_q;

    assign w_capturing   = (r_state == ST_PRE) || (r_state == ST_WAIT_TRIG) || (r_state == ST_POST);
    assign w_accept      = w_capturing && sample_valid && (r_dec_cnt == '0);
    assign w_cnt_inc     = r_cnt + 1'b1;
    assign w_post_len    = CNT_W'(DEPTH) - {1'b0, r_pre_len};
    assign w_pre_last    = (w_cnt_inc == {1'b0, r_pre_len});
    assign w_post_last   = (w_cnt_inc == w_post_len);
    assign w_wdata       = mark ? {CHANNELS{MARK_CODE}} : sample_data;

    // Two-stage readout: RAM output register, then the tx byte register.
    assign w_out_free    = !r_tx_valid || tx_ready;
    assign w_take        = r_s1_valid && w_out_free;
    assign w_issue       = (r_state == ST_DUMP) && !r_issue_done && (!r_s1_valid || w_take);
    assign w_final_issue = (r_rd_ch == LAST_CH) && (r_rd_i == LAST_IDX);
    assign w_last_accept = r_tx_valid && tx_ready && r_tx_last;

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      if (arm) w_state_next = (pretrig_len == '0) ? ST_WAIT_TRIG : ST_PRE;
                ST_PRE:       if (w_accept && w_pre_last) w_state_next = ST_WAIT_TRIG;
                ST_WAIT_TRIG: if (trig) w_state_next = ST_POST;
                ST_POST:      if (w_accept && w_post_last) w_state_next = ST_DUMP;
                ST_DUMP:      if (w_last_accept) w_state_next = ST_FIN;
                ST_FIN:       w_state_next = ST_IDLE;
                default:      w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pre_len   <= '0;
            r_decim     <= '0;
            r_dec_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_triggered <= (w_state_next == ST_POST) || (w_state_next == ST_DUMP) ||
                           (w_state_next == ST_FIN);
            r_done      <= (w_state_next == ST_FIN);
            // pretrig_len is AW bits wide, so it can never exceed DEPTH-1.
            if ((r_state == ST_IDLE) && arm && !abort) begin
                r_pre_len <= pretrig_len;
                r_decim   <= decim;
                r_dec_cnt <= '0;
                r_wr_ptr  <= '0;
                r_cnt     <= '0;
            end else if (w_capturing) begin
                if (sample_valid) begin
                    r_dec_cnt <= (r_dec_cnt == r_decim) ? '0 : r_dec_cnt + 1'b1;
                end
                if (w_accept) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_state_next != r_state) begin
                    r_cnt <= '0;
                end else if (w_accept && (r_state != ST_WAIT_TRIG)) begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    // After POST the write pointer sits on the oldest sample, so it is the read base.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ch      <= '0;
            r_rd_i       <= '0;
            r_issue_done <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_ch      <= '0;
            r_s1_last    <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_tx_last    <= 1'b0;
        end else if ((r_state != ST_DUMP) || (w_state_next != ST_DUMP)) begin
            r_rd_ch      <= '0;
            r_rd_i       <= '0;
            r_issue_done <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_last    <= 1'b0;
        end else begin
            if (w_issue) begin
                r_s1_ch   <= r_rd_ch;
                r_s1_last <= w_final_issue;
                r_rd_i    <= r_rd_i + 1'b1;
                if (r_rd_i == LAST_IDX) begin
                    r_rd_ch <= r_rd_ch + 1'b1;
                end
                if (w_final_issue) begin
                    r_issue_done <= 1'b1;
                end
            end
            if (w_issue) begin
                r_s1_valid <= 1'b1;
            end else if (w_take) begin
                r_s1_valid <= 1'b0;
            end
            if (w_take) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_ram_q[r_s1_ch*SAMPLE_W +: SAMPLE_W];
                r_tx_last  <= r_s1_last;
            end else if (tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    trace_ram #(
        .WIDTH  (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_re    (w_issue),
        .i_raddr (r_wr_ptr + r_rd_i),
        .o_rdata (w_ram_q)
    );

    assign busy      = (r_state != ST_IDLE);
    assign triggered = r_triggered;
    assign done      = r_done;
    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;

endmodule
